instruction_fetch: RTL and testbench

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/instruction_fetch.sv | 99 +++++++++
 tb/tb_instruction_fetch.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// Instruction fetch unit: reads one 16-bit word per PC from instruction memory and
// hands it to the decoder. It supports jumps and a sticky memory-timeout fault.
module instruction_fetch (
    input  logic        i_CLK,
    input  logic        i_RST,
    input  logic        i_Run,
    output logic        o_MemReq,
    output logic [7:0]  o_MemAddr,
    input  logic        i_MemAck,
    input  logic [15:0] i_MemData,
    output logic [15:0] o_Instr,
    output logic        o_InstrValid,
    input  logic        i_DecReady,
    input  logic        i_JumpEn,
    input  logic [7:0]  i_JumpAddr,
    output logic [7:0]  o_PC,
    output logic        o_Fault
);

    typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;

    state_t      state_q, state_d;
    logic [7:0]  pc_q, pc_d;
    logic [15:0] instr_q, instr_d;
    logic [3:0]  tmo_q, tmo_d;
    logic        fault_q, fault_d;
    // Armed one edge after reset release, so the first request appears on the second edge.
    logic        armed_q;

    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            state_q <= IDLE;
            pc_q    <= 8'h00;
            instr_q <= 16'h0000;
            tmo_q   <= 4'd0;
            fault_q <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            tmo_q   <= tmo_d;
            fault_q <= fault_d;
            armed_q <= 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        tmo_d   = tmo_q;
        fault_d = fault_q;
        unique case (state_q)
            IDLE: begin
                if (i_JumpEn)
                    pc_d = i_JumpAddr;
                if (i_Run && !fault_q && armed_q) begin
                    state_d = FETCH;
                    tmo_d   = 4'd0;
                end
            end
            FETCH: begin
                // A jump overrides a coinciding ack: the returned word belongs to the old PC.
                if (i_JumpEn) begin
                    pc_d  = i_JumpAddr;
                    tmo_d = 4'd0;
                end else if (i_MemAck) begin
                    instr_d = i_MemData;
                    pc_d    = pc_q + 8'd1;
                    state_d = HOLD;
                end else begin
                    tmo_d = tmo_q + 4'd1;
                    if (tmo_q == 4'd14) begin
                        fault_d = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            HOLD: begin
                if (i_JumpEn)
                    pc_d = i_JumpAddr;
                if (i_JumpEn || i_DecReady) begin
                    state_d = i_Run ? FETCH : IDLE;
                    tmo_d   = 4'd0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign o_MemReq     = (state_q == FETCH);
    assign o_MemAddr    = pc_q;
    assign o_PC         = pc_q;
    assign o_Instr      = instr_q;
    assign o_InstrValid = (state_q == HOLD);
    assign o_Fault      = fault_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: inputs change and outputs are sampled on the falling edge.
module tb_instruction_fetch;

    logic        i_CLK = 1'b0;
    logic        i_RST;
    logic        i_Run;
    logic        o_MemReq;
    logic [7:0]  o_MemAddr;
    logic        i_MemAck;
    logic [15:0] i_MemData;
    logic [15:0] o_Instr;
    logic        o_InstrValid;
    logic        i_DecReady;
    logic        i_JumpEn;
    logic [7:0]  i_JumpAddr;
    logic [7:0]  o_PC;
    logic        o_Fault;

    int n_chk = 0;
    int n_err = 0;

    instruction_fetch dut (
        .i_CLK       (i_CLK),
        .i_RST       (i_RST),
        .i_Run       (i_Run),
        .o_MemReq    (o_MemReq),
        .o_MemAddr   (o_MemAddr),
        .i_MemAck    (i_MemAck),
        .i_MemData   (i_MemData),
        .o_Instr     (o_Instr),
        .o_InstrValid(o_InstrValid),
        .i_DecReady  (i_DecReady),
        .i_JumpEn    (i_JumpEn),
        .i_JumpAddr  (i_JumpAddr),
        .o_PC        (o_PC),
        .o_Fault     (o_Fault)
    );

    always #5 i_CLK = ~i_CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_CLK);
        @(negedge i_CLK);
    endtask

    initial begin
        i_RST = 1'b1; i_Run = 1'b0; i_MemAck = 1'b0; i_MemData = 16'h0000;
        i_DecReady = 1'b0; i_JumpEn = 1'b0; i_JumpAddr = 8'h00;
        @(negedge i_CLK);
        tick();
        check("rst_req",   32'(o_MemReq), 32'h0);
        check("rst_valid", 32'(o_InstrValid), 32'h0);
        check("rst_pc",    32'(o_PC), 32'h00);
        check("rst_instr", 32'(o_Instr), 32'h0000);
        check("rst_fault", 32'(o_Fault), 32'h0);

        // Reset release: request appears on the second rising edge
        i_RST = 1'b0; i_Run = 1'b1;
        tick();
        check("rel_edge1_req", 32'(o_MemReq), 32'h0);
        tick();
        check("rel_edge2_req",  32'(o_MemReq), 32'h1);
        check("rel_edge2_addr", 32'(o_MemAddr), 32'h00);

        // Basic fetch
        i_MemAck = 1'b1; i_MemData = 16'h1234; i_DecReady = 1'b1;
        tick();
        i_MemAck = 1'b0;
        check("basic_valid", 32'(o_InstrValid), 32'h1);
        check("basic_instr", 32'(o_Instr), 32'h1234);
        check("basic_pc",    32'(o_PC), 32'h01);
        check("basic_req",   32'(o_MemReq), 32'h0);
        tick();
        check("basic_valid_fall", 32'(o_InstrValid), 32'h0);
        check("basic_refetch",    32'(o_MemReq), 32'h1);
        check("basic_next_addr",  32'(o_MemAddr), 32'h01);

        // Back-pressure
        i_DecReady = 1'b0; i_MemAck = 1'b1; i_MemData = 16'hABCD;
        tick();
        i_MemAck = 1'b0;
        for (int k = 0; k < 5; k++) begin
            check("bp_valid", 32'(o_InstrValid), 32'h1);
            check("bp_instr", 32'(o_Instr), 32'hABCD);
            check("bp_req",   32'(o_MemReq), 32'h0);
            tick();
        end
        i_DecReady = 1'b1;
        tick();
        check("bp_release_addr", 32'(o_MemAddr), 32'h02);
        check("bp_release_req",  32'(o_MemReq), 32'h1);

        // Jump colliding with ack in FETCH
        i_JumpEn = 1'b1; i_JumpAddr = 8'h40; i_MemAck = 1'b1; i_MemData = 16'hDEAD;
        tick();
        i_JumpEn = 1'b0; i_MemAck = 1'b0;
        check("jf_req",   32'(o_MemReq), 32'h1);
        check("jf_addr",  32'(o_MemAddr), 32'h40);
        check("jf_instr", 32'(o_Instr), 32'hABCD);
        check("jf_valid", 32'(o_InstrValid), 32'h0);

        // Jump in HOLD discards the held word
        i_DecReady = 1'b0; i_MemAck = 1'b1; i_MemData = 16'h5555;
        tick();
        i_MemAck = 1'b0;
        check("jh_pre_valid", 32'(o_InstrValid), 32'h1);
        check("jh_pre_pc",    32'(o_PC), 32'h41);
        i_JumpEn = 1'b1; i_JumpAddr = 8'h40;
        tick();
        i_JumpEn = 1'b0;
        check("jh_valid", 32'(o_InstrValid), 32'h0);
        check("jh_req",   32'(o_MemReq), 32'h1);
        check("jh_addr",  32'(o_MemAddr), 32'h40);
        i_MemAck = 1'b1; i_MemData = 16'h7777;
        tick();
        i_MemAck = 1'b0;
        check("jh_refetch_instr", 32'(o_Instr), 32'h7777);
        check("jh_refetch_pc",    32'(o_PC), 32'h41);

        // Wrap-around
        i_JumpEn = 1'b1; i_JumpAddr = 8'hFF;
        tick();
        i_JumpEn = 1'b0;
        check("wrap_addr", 32'(o_MemAddr), 32'hFF);
        i_MemAck = 1'b1; i_MemData = 16'h0F0F; i_DecReady = 1'b1;
        tick();
        i_MemAck = 1'b0;
        check("wrap_pc",    32'(o_PC), 32'h00);
        check("wrap_instr", 32'(o_Instr), 32'h0F0F);
        tick();
        check("wrap_next_addr", 32'(o_MemAddr), 32'h00);

        // Run drop mid-FETCH: read completes, handed off, then IDLE
        i_Run = 1'b0; i_DecReady = 1'b0;
        tick();
        check("rd_req_kept", 32'(o_MemReq), 32'h1);
        i_MemAck = 1'b1; i_MemData = 16'h1111;
        tick();
        i_MemAck = 1'b0;
        check("rd_valid", 32'(o_InstrValid), 32'h1);
        check("rd_instr", 32'(o_Instr), 32'h1111);
        i_DecReady = 1'b1;
        tick();
        check("rd_idle_valid", 32'(o_InstrValid), 32'h0);
        check("rd_idle_req",   32'(o_MemReq), 32'h0);
        tick();
        check("rd_idle_stay",  32'(o_MemReq), 32'h0);

        // Ignored handshakes outside their states
        i_MemAck = 1'b1; i_MemData = 16'hBEEF;
        tick();
        i_MemAck = 1'b0;
        check("ign_ack_instr", 32'(o_Instr), 32'h1111);

        // Reset pulse mid-HOLD acts without a clock edge
        i_Run = 1'b1; i_DecReady = 1'b0;
        tick();
        i_MemAck = 1'b1; i_MemData = 16'h2222;
        tick();
        i_MemAck = 1'b0;
        check("rh_pre_valid", 32'(o_InstrValid), 32'h1);
        #1 i_RST = 1'b1;
        #1;
        check("rh_valid", 32'(o_InstrValid), 32'h0);
        check("rh_req",   32'(o_MemReq), 32'h0);
        check("rh_instr", 32'(o_Instr), 32'h0000);
        check("rh_pc",    32'(o_PC), 32'h00);
        tick();
        i_RST = 1'b0;

        // Timeout: 15 FETCH cycles without ack
        tick();
        tick();
        check("to_first_req", 32'(o_MemReq), 32'h1);
        for (int k = 0; k < 14; k++) begin
            tick();
            check("to_req_held", 32'(o_MemReq), 32'h1);
            check("to_no_fault", 32'(o_Fault), 32'h0);
        end
        tick();
        check("to_fault", 32'(o_Fault), 32'h1);
        check("to_req",   32'(o_MemReq), 32'h0);
        i_JumpEn = 1'b1; i_JumpAddr = 8'h33;
        tick();
        i_JumpEn = 1'b0;
        check("to_idle_jump_pc", 32'(o_PC), 32'h33);
        for (int k = 0; k < 4; k++) begin
            tick();
            check("to_stuck_req",   32'(o_MemReq), 32'h0);
            check("to_stuck_fault", 32'(o_Fault), 32'h1);
        end
        i_RST = 1'b1;
        #1;
        check("to_rst_fault", 32'(o_Fault), 32'h0);
        tick();
        i_RST = 1'b0;
        tick();
        tick();
        check("to_after_rst_req", 32'(o_MemReq), 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
